// File: rtl/regfile_writeback.sv
// regfile_writeback: ALU/load write-port arbiter with per-register pending-write scoreboard.
// Define REGFILE_WB_BYPASS_EN to add write-port forwarding outputs for rs1/rs2.
module regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    output logic                  issue_ready,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    input  logic [4:0]            mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic [4:0]            rf_a3,
    output logic [DATA_WIDTH-1:0] rf_wd3,
    output logic                  rf_we3,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                  rs1_fwd_hit,
    output logic                  rs2_fwd_hit,
    output logic [DATA_WIDTH-1:0] rs1_fwd_data,
    output logic [DATA_WIDTH-1:0] rs2_fwd_data,
`endif
    output logic                  sb_underflow
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  cnt_q [32];
    logic [CNT_WIDTH-1:0]  cnt_d [32];
    logic                  rf_we3_q, rf_we3_d;
    logic [4:0]            rf_a3_q, rf_a3_d;
    logic [DATA_WIDTH-1:0] rf_wd3_q, rf_wd3_d;
    logic                  sb_underflow_q, sb_underflow_d;
    logic                  issue_fire, res_valid;
    logic [4:0]            res_rd;
    logic [DATA_WIDTH-1:0] res_data;
    logic [31:0]           inc_vec, dec_vec;
    logic                  rs1_pend, rs2_pend;

    always_comb begin
        issue_ready    = rst_n && (issue_rd == 5'd0 || cnt_q[issue_rd] != CNT_MAX);
        mem_ready      = rst_n && !alu_valid;
        issue_fire     = issue_valid && issue_ready && issue_rd != 5'd0;
        res_valid      = alu_valid || (mem_valid && mem_ready);
        res_rd         = alu_valid ? alu_rd : mem_rd;
        res_data       = alu_valid ? alu_data : mem_data;
        // rd=0 results are consumed but never reach the write port
        rf_we3_d       = rst_n && res_valid && res_rd != 5'd0;
        rf_a3_d        = rf_we3_d ? res_rd : rf_a3_q;
        rf_wd3_d       = rf_we3_d ? res_data : rf_wd3_q;
        sb_underflow_d = sb_underflow_q || (rf_we3_q && cnt_q[rf_a3_q] == '0);
        inc_vec        = issue_fire ? (32'd1 << issue_rd) : 32'd0;
        dec_vec        = rf_we3_q ? (32'd1 << rf_a3_q) : 32'd0;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (inc_vec[r] && !dec_vec[r]) ? cnt_q[r] + CNT_ONE :
                       (dec_vec[r] && !inc_vec[r] && cnt_q[r] != '0) ? cnt_q[r] - CNT_ONE :
                       cnt_q[r];
        end
        rs1_pend       = rs1 != 5'd0 && cnt_q[rs1] != '0;
        rs2_pend       = rs2 != 5'd0 && cnt_q[rs2] != '0;
`ifdef REGFILE_WB_BYPASS_EN
        rs1_fwd_hit    = rf_we3_q && rf_a3_q == rs1 && rs1 != 5'd0;
        rs2_fwd_hit    = rf_we3_q && rf_a3_q == rs2 && rs2 != 5'd0;
        rs1_fwd_data   = rf_wd3_q;
        rs2_fwd_data   = rf_wd3_q;
        // the last outstanding write is on the port now, so the forwarded value is final
        rs1_busy       = rs1_pend && !(rs1_fwd_hit && cnt_q[rs1] == CNT_ONE);
        rs2_busy       = rs2_pend && !(rs2_fwd_hit && cnt_q[rs2] == CNT_ONE);
`else
        rs1_busy       = rs1_pend;
        rs2_busy       = rs2_pend;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '{default: '0};
            rf_we3_q       <= 1'b0;
            rf_a3_q        <= 5'd0;
            rf_wd3_q       <= '0;
            sb_underflow_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            rf_we3_q       <= rf_we3_d;
            rf_a3_q        <= rf_a3_d;
            rf_wd3_q       <= rf_wd3_d;
            sb_underflow_q <= sb_underflow_d;
        end
    end

    assign rf_we3       = rf_we3_q;
    assign rf_a3        = rf_a3_q;
    assign rf_wd3       = rf_wd3_q;
    assign sb_underflow = sb_underflow_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard bench; expected writes queued at drive time, popped on rf_we3.
module tb_regfile_writeback;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, rf_a3;
    logic [31:0] alu_data, mem_data, rf_wd3;
    logic        rf_we3, sb_underflow;
`ifdef REGFILE_WB_BYPASS_EN
    logic        rs1_fwd_hit, rs2_fwd_hit;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif
    int          checks = 0;
    int          failures = 0;
    logic [36:0] exp_q[$];

    regfile_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
`ifdef REGFILE_WB_BYPASS_EN
        .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
        .sb_underflow(sb_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rst_n && rf_we3) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected got a3=%0d wd3=%h, none expected", rf_a3, rf_wd3);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_a3, rf_wd3} !== e) begin
                    failures++;
                    $display("FAIL wb_data got a3=%0d wd3=%h want a3=%0d wd3=%h", rf_a3, rf_wd3, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd = rd;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic alu_write(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd = rd;
        alu_data = d;
        if (rd != 5'd0) exp_q.push_back({rd, d});
        step();
        alu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks += 7;
        if (rf_we3 !== 1'b0) begin failures++; $display("FAIL rst_we3 got %b want 0", rf_we3); end
        if (rf_a3 !== 5'd0) begin failures++; $display("FAIL rst_a3 got %0d want 0", rf_a3); end
        if (rf_wd3 !== 32'd0) begin failures++; $display("FAIL rst_wd3 got %h want 0", rf_wd3); end
        if (sb_underflow !== 1'b0) begin failures++; $display("FAIL rst_underflow got %b want 0", sb_underflow); end
        if (issue_ready !== 1'b0) begin failures++; $display("FAIL rst_issue_ready got %b want 0", issue_ready); end
        if (mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_ready got %b want 0", mem_ready); end
        rst_n = 1'b1;
        rs1 = 5'd5;
        #1;
        if (rs1_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", rs1_busy); end
        step();
    endtask

    task automatic test_alu_commit();
        rs1 = 5'd5;
        issue_rd = 5'd5;
        #1;
        checks += 6;
        if (issue_ready !== 1'b1) begin failures++; $display("FAIL t1_issue_ready got %b want 1", issue_ready); end
        issue(5'd5);
        if (rs1_busy !== 1'b1) begin failures++; $display("FAIL t1_busy_n got %b want 1", rs1_busy); end
        alu_write(5'd5, 32'hDEADBEEF);
        if (rf_we3 !== 1'b1 || rf_a3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL t1_port got we=%b a3=%0d wd3=%h want 1/5/deadbeef", rf_we3, rf_a3, rf_wd3);
        end
        if (rs1_busy !== !BYP) begin failures++; $display("FAIL t1_busy_n1 got %b want %b", rs1_busy, !BYP); end
        step();
        if (rs1_busy !== 1'b0) begin failures++; $display("FAIL t1_busy_n2 got %b want 0", rs1_busy); end
        if (rf_we3 !== 1'b0 || rf_a3 !== 5'd5) begin failures++; $display("FAIL t1_idle got we=%b a3=%0d want 0/5", rf_we3, rf_a3); end
    endtask

    task automatic test_arbitration();
        issue(5'd3);
        issue(5'd4);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA0A0_0003;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB0B0_0004;
        exp_q.push_back({5'd3, 32'hA0A0_0003});
        #1;
        checks += 4;
        if (mem_ready !== 1'b0) begin failures++; $display("FAIL t2_mem_ready_n got %b want 0", mem_ready); end
        step();
        alu_valid = 1'b0;
        exp_q.push_back({5'd4, 32'hB0B0_0004});
        #1;
        if (mem_ready !== 1'b1) begin failures++; $display("FAIL t2_mem_ready_n1 got %b want 1", mem_ready); end
        if (rf_a3 !== 5'd3) begin failures++; $display("FAIL t2_alu_first got a3=%0d want 3", rf_a3); end
        step();
        mem_valid = 1'b0;
        if (rf_we3 !== 1'b1 || rf_a3 !== 5'd4 || rf_wd3 !== 32'hB0B0_0004) begin
            failures++; $display("FAIL t2_load got we=%b a3=%0d wd3=%h want 1/4/b0b00004", rf_we3, rf_a3, rf_wd3);
        end
        step();
    endtask

    task automatic test_saturation();
        checks += 6;
        for (int i = 0; i < 3; i++) issue(5'd7);
        issue_rd = 5'd7;
        issue_valid = 1'b1;
        #1;
        if (issue_ready !== 1'b0) begin failures++; $display("FAIL t3_sat got %b want 0", issue_ready); end
        alu_write(5'd7, 32'h0000_0777);
        issue_valid = 1'b1;
        #1;
        if (issue_ready !== 1'b0) begin failures++; $display("FAIL t3_sat_commit got %b want 0", issue_ready); end
        step();
        issue_valid = 1'b0;
        #1;
        if (issue_ready !== 1'b1) begin failures++; $display("FAIL t3_after_commit got %b want 1", issue_ready); end
        rs1 = 5'd7;
        alu_write(5'd7, 32'h0000_0778);
        alu_write(5'd7, 32'h0000_0779);
        if (rs1_busy !== !BYP) begin failures++; $display("FAIL t3_last_pending got %b want %b", rs1_busy, !BYP); end
        step();
        if (rs1_busy !== 1'b0) begin failures++; $display("FAIL t3_drained got %b want 0", rs1_busy); end
        if (sb_underflow !== 1'b0) begin failures++; $display("FAIL t3_no_underflow got %b want 0", sb_underflow); end
    endtask

    task automatic test_rd0_underflow();
        checks += 5;
        issue(5'd10);
        rs2 = 5'd10;
        alu_write(5'd0, 32'h0000_1234);
        if (rf_we3 !== 1'b0) begin failures++; $display("FAIL t4_rd0_we got %b want 0", rf_we3); end
        if (rs2_busy !== 1'b1) begin failures++; $display("FAIL t4_rd0_busy got %b want 1", rs2_busy); end
        alu_write(5'd10, 32'h0000_00AA);
        rs1 = 5'd9;
        alu_write(5'd9, 32'h0000_0099);
        if (sb_underflow !== 1'b0) begin failures++; $display("FAIL t4_pre_underflow got %b want 0", sb_underflow); end
        step();
        if (sb_underflow !== 1'b1) begin failures++; $display("FAIL t4_underflow got %b want 1", sb_underflow); end
        if (rs1_busy !== 1'b0) begin failures++; $display("FAIL t4_idle_busy got %b want 0", rs1_busy); end
        step();
    endtask

    task automatic test_reset_mid();
        checks += 8;
        issue(5'd6);
        issue(5'd6);
        rs1 = 5'd6;
        alu_write(5'd6, 32'h6666_6666);
        rst_n = 1'b0;
        #1;
        if (rf_we3 !== 1'b1) begin failures++; $display("FAIL t5_pending got %b want 1", rf_we3); end
        if (issue_ready !== 1'b0) begin failures++; $display("FAIL t5_issue_ready got %b want 0", issue_ready); end
        if (mem_ready !== 1'b0) begin failures++; $display("FAIL t5_mem_ready got %b want 0", mem_ready); end
        exp_q.delete();
        step();
        if (rf_we3 !== 1'b0) begin failures++; $display("FAIL t5_we_dropped got %b want 0", rf_we3); end
        if (rs1_busy !== 1'b0) begin failures++; $display("FAIL t5_busy got %b want 0", rs1_busy); end
        rst_n = 1'b1;
        step();
        if (rf_we3 !== 1'b0) begin failures++; $display("FAIL t5_we_after got %b want 0", rf_we3); end
        if (sb_underflow !== 1'b0) begin failures++; $display("FAIL t5_underflow got %b want 0", sb_underflow); end
        if (rs1_busy !== 1'b0) begin failures++; $display("FAIL t5_busy_after got %b want 0", rs1_busy); end
    endtask

`ifdef REGFILE_WB_BYPASS_EN
    task automatic test_bypass();
        checks += 5;
        issue(5'd8);
        rs2 = 5'd8;
        rs1 = 5'd0;
        alu_write(5'd8, 32'h0000_0055);
        if (rs2_busy !== 1'b0) begin failures++; $display("FAIL t6_busy got %b want 0", rs2_busy); end
        if (rs2_fwd_hit !== 1'b1) begin failures++; $display("FAIL t6_hit got %b want 1", rs2_fwd_hit); end
        if (rs2_fwd_data !== 32'h55) begin failures++; $display("FAIL t6_data got %h want 00000055", rs2_fwd_data); end
        if (rs1_fwd_hit !== 1'b0) begin failures++; $display("FAIL t6_rs0_hit got %b want 0", rs1_fwd_hit); end
        step();
        if (rs2_fwd_hit !== 1'b0) begin failures++; $display("FAIL t6_hit_gone got %b want 0", rs2_fwd_hit); end
    endtask
`endif

    task automatic test_drain();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        test_reset();
        test_alu_commit();
        test_arbitration();
        test_saturation();
        test_rd0_underflow();
        test_reset_mid();
`ifdef REGFILE_WB_BYPASS_EN
        test_bypass();
`endif
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
